// File: rtl/DW_fp_add.sv
// rtl/DW_fp_add.sv - floating-point adder, round to nearest even, denormals flushed to zero
module DW_fp_add #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);
  localparam int W  = sig_width + 1;
  localparam int X  = W + 3;
  localparam int P  = 1 << exp_width;
  localparam int EW = exp_width + 2;
  localparam bit QUIET_NAN = (ieee_compliance != 0);
  localparam logic [exp_width-1:0] EMAX    = {exp_width{1'b1}};
  localparam logic signed [EW-1:0] ER_MAX  = {2'b00, EMAX};
  localparam logic signed [EW-1:0] ER_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] ER_ZERO = '0;

  logic                  sa, sb, sl, ss;
  logic [exp_width-1:0]  ea, eb, el, es, d;
  logic [sig_width-1:0]  ma, mb, ml, ms;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [X-1:0]          big, sml, sml_sh, nrm;
  logic [X+P-1:0]        shf;
  logic [X:0]            sum;
  logic [W:0]            mr;
  logic signed [EW-1:0]  er;
  logic                  up;
  logic                  unused_bits;

  always_comb begin
    sa = a[sig_width+exp_width];
    ea = a[sig_width+exp_width-1:sig_width];
    ma = a[sig_width-1:0];
    sb = b[sig_width+exp_width];
    eb = b[sig_width+exp_width-1:sig_width];
    mb = b[sig_width-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EMAX) && (ma == '0);
    b_inf  = (eb == EMAX) && (mb == '0);
    a_nan  = (ea == EMAX) && (ma != '0);
    b_nan  = (eb == EMAX) && (mb != '0);

    // Order by magnitude so the subtraction below never goes negative.
    if ({ea, ma} >= {eb, mb}) begin
      sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
    end else begin
      sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
    end
    d   = el - es;
    big = {1'b1, ml, 3'b000};
    sml = {1'b1, ms, 3'b000};

    // Shift room covers every exponent difference, so nothing escapes the sticky OR.
    shf    = {sml, {P{1'b0}}} >> d;
    sml_sh = shf[X+P-1:P] | {{(X-1){1'b0}}, |shf[P-1:0]};
    sum    = (sl ^ ss) ? ({1'b0, big} - {1'b0, sml_sh}) : ({1'b0, big} + {1'b0, sml_sh});

    er = $signed({2'b00, el});
    if (sum[X]) begin
      nrm = sum[X:1] | {{(X-1){1'b0}}, sum[0]};
      er  = er + ER_ONE;
    end else begin
      nrm = sum[X-1:0];
    end
    for (int i = 0; i < X; i++) begin
      if (!nrm[X-1] && (nrm != '0)) begin
        nrm = nrm << 1;
        er  = er - ER_ONE;
      end
    end

    up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mr = {1'b0, nrm[X-1:3]} + {{W{1'b0}}, up};
    if (mr[W]) er = er + ER_ONE;

    z      = '0;
    status = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      z         = {1'b0, EMAX, QUIET_NAN, {(sig_width-1){1'b0}}};
      status[2] = 1'b1;
    end else if (a_inf) begin
      z         = {sa, EMAX, {sig_width{1'b0}}};
      status[1] = 1'b1;
    end else if (b_inf) begin
      z         = {sb, EMAX, {sig_width{1'b0}}};
      status[1] = 1'b1;
    end else if (a_zero && b_zero) begin
      z = {sa & sb, {(exp_width+sig_width){1'b0}}};
    end else if (a_zero) begin
      z = b;
    end else if (b_zero) begin
      z = a;
    end else if (sum == '0) begin
      z = '0;
    end else if (er >= ER_MAX) begin
      z         = {sl, EMAX, {sig_width{1'b0}}};
      status[1] = 1'b1;
    end else if (er <= ER_ZERO) begin
      z = {sl, {(exp_width+sig_width){1'b0}}};
    end else begin
      z = {sl, er[exp_width-1:0], mr[sig_width-1:0]};
    end
    status[0]   = (z[sig_width+exp_width-1:0] == '0);
    unused_bits = ^{rnd, mr[W-1]};
  end
endmodule

// File: rtl/reduce4_acc.sv
// rtl/reduce4_acc.sv - four-lane half-precision tree reduction with vector accumulator
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef IEEE_COMPLIANCE
`define IEEE_COMPLIANCE 0
`endif

module reduce4_acc #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [`DATAWIDTH-1:0] inp0,
  input  logic [`DATAWIDTH-1:0] inp1,
  input  logic [`DATAWIDTH-1:0] inp2,
  input  logic [`DATAWIDTH-1:0] inp3,
  output logic                  in_ready,
  output logic [`DATAWIDTH-1:0] outp,
  output logic                  outp_valid,
  output logic [CNT_WIDTH-1:0]  group_cnt,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                state, state_next;
  logic                  accept;
  logic [`DATAWIDTH-1:0] sum01, sum23, tree_sum, acc_sum, final_sum;
  logic [`DATAWIDTH-1:0] s1_sum, acc;
  logic                  s1_valid, s1_last, acc_first;
  logic [7:0]            st01, st23, st_tree, st_acc;
  logic                  status_unused;

  DW_fp_add #(.sig_width(`MANTISSA), .exp_width(`EXPONENT), .ieee_compliance(`IEEE_COMPLIANCE))
    u_add01 (.a(inp0), .b(inp1), .rnd(3'b000), .z(sum01), .status(st01));
  DW_fp_add #(.sig_width(`MANTISSA), .exp_width(`EXPONENT), .ieee_compliance(`IEEE_COMPLIANCE))
    u_add23 (.a(inp2), .b(inp3), .rnd(3'b000), .z(sum23), .status(st23));
  DW_fp_add #(.sig_width(`MANTISSA), .exp_width(`EXPONENT), .ieee_compliance(`IEEE_COMPLIANCE))
    u_add_tree (.a(sum01), .b(sum23), .rnd(3'b000), .z(tree_sum), .status(st_tree));
  DW_fp_add #(.sig_width(`MANTISSA), .exp_width(`EXPONENT), .ieee_compliance(`IEEE_COMPLIANCE))
    u_add_acc (.a(acc), .b(s1_sum), .rnd(3'b000), .z(acc_sum), .status(st_acc));

  assign status_unused = ^{st01, st23, st_tree, st_acc};

  // The first group of a vector bypasses the adder so a -0 sum is not turned into +0.
  assign final_sum = acc_first ? s1_sum : acc_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (!start && in_valid && in_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (start)                      state_next = ACCUM;
        else if (s1_valid && s1_last)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // start wins over a group presented on the same edge
    accept = in_valid && in_ready && !start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sum     <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      acc        <= '0;
      acc_first  <= 1'b0;
      outp       <= '0;
      outp_valid <= 1'b0;
      group_cnt  <= '0;
    end else begin
      outp_valid <= 1'b0;
      if (start) begin
        s1_valid  <= 1'b0;
        s1_last   <= 1'b0;
        acc       <= '0;
        acc_first <= 1'b1;
        group_cnt <= '0;
      end else begin
        s1_valid <= accept;
        s1_last  <= accept && in_last;
        if (accept) begin
          s1_sum <= tree_sum;
          if (group_cnt != {CNT_WIDTH{1'b1}}) group_cnt <= group_cnt + 1'b1;
        end
        if (s1_valid) begin
          acc       <= final_sum;
          acc_first <= 1'b0;
          if (s1_last) begin
            outp       <= final_sum;
            outp_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule
